// File: rtl/lifo_arbiter_if.sv
// Requester and LIFO-side signal bundle for lifo_arbiter.
// slave = arbiter view, master = requesters plus LIFO (environment) view.
interface lifo_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_op;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               lifo_push;
  logic               lifo_pop;
  logic [DW-1:0]      lifo_din;
  logic [DW-1:0]      lifo_dout;
  logic               lifo_full;
  logic               lifo_empty;
  logic               lifo_error;

  modport slave (
    input  req_valid, req_op, req_data, lifo_dout, lifo_full, lifo_empty, lifo_error,
    output req_ready, rsp_valid, rsp_data, rsp_err, lifo_push, lifo_pop, lifo_din
  );

  modport master (
    output req_valid, req_op, req_data, lifo_dout, lifo_full, lifo_empty, lifo_error,
    input  req_ready, rsp_valid, rsp_data, rsp_err, lifo_push, lifo_pop, lifo_din
  );
endinterface

// File: rtl/lifo_arbiter.sv
// Serialises NREQ push/pop requesters onto a single LIFO port, one transaction per 3 cycles.
// Define LIFO_ARB_PRIO_EN for fixed lowest-index priority; default is round-robin.
module lifo_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  lifo_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_win;
  logic            w_any;
  logic            w_xfer;
  logic            w_push;
  logic            w_pop;
  logic            w_rej;
  logic [NREQ-1:0] w_ready;
  logic [IW-1:0]   r_win;
  logic            r_op;
  logic [DW-1:0]   r_data;
  logic            r_rej;
  logic            r_pop_ok;
  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;
  logic            r_rsp_err;
`ifndef LIFO_ARB_PRIO_EN
  logic [IW-1:0]   r_ptr;
`endif

  // Winner search: first valid requester starting at the pointer (or at 0 in priority mode)
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef LIFO_ARB_PRIO_EN
      w_idx = IW'(k);
`else
      w_idx = IW'((32'(r_ptr) + k) % NREQ);
`endif
      if (!w_any && bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_rej       = 1'b0;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_ready[w_win] = 1'b1;
          w_xfer         = 1'b1;
          w_state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!r_op) begin
          if (!bus.lifo_full) w_push = 1'b1;
          else                w_rej  = 1'b1;
        end else begin
          if (!bus.lifo_empty) w_pop = 1'b1;
          else                 w_rej = 1'b1;
        end
        w_state_nxt = S_CAPT;
      end
      S_CAPT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transaction latch and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win       <= '0;
      r_op        <= 1'b0;
      r_data      <= '0;
      r_rej       <= 1'b0;
      r_pop_ok    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_win  <= w_win;
        r_op   <= bus.req_op[w_win];
        r_data <= bus.req_data[32'(w_win)*DW +: DW];
      end
      if (r_state == S_ISSUE) begin
        r_rej    <= w_rej;
        r_pop_ok <= w_pop;
      end
      r_rsp_valid <= '0;
      if (r_state == S_CAPT) begin
        r_rsp_valid[r_win] <= 1'b1;
        r_rsp_err          <= r_rej | bus.lifo_error;
        r_rsp_data         <= r_pop_ok ? bus.lifo_dout : '0;
      end
    end
  end

`ifndef LIFO_ARB_PRIO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_ptr <= '0;
    else if (w_xfer) r_ptr <= (32'(w_win) == NREQ - 1) ? '0 : w_win + IW'(1);
  end
`endif

  // Grant is masked by reset so the port is quiet while rst is low
  assign bus.req_ready = rst ? w_ready : '0;
  assign bus.lifo_push = w_push;
  assign bus.lifo_pop  = w_pop;
  assign bus.lifo_din  = w_push ? r_data : '0;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench for lifo_arbiter: directed vector table, hand sequences, and random traffic
// against a transaction-level model with its own reference stack.
module tb_lifo_arbiter;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned DW    = 8;
  localparam int          DEPTH = 16;
  localparam int          NRAND = 600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lifo_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
  lifo_arbiter #(.NREQ(NREQ), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk = 0;
  int n_err = 0;

  // Behavioural 16-deep LIFO answering the strobes
  logic [DW-1:0] stk[$];
  int            stk_n = 0;
  assign bus.lifo_full  = (stk_n == DEPTH);
  assign bus.lifo_empty = (stk_n == 0);
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      stk.delete();
      bus.lifo_dout <= '0;
    end else begin
      if (bus.lifo_push && stk.size() < DEPTH) stk.push_back(bus.lifo_din);
      if (bus.lifo_pop && stk.size() > 0) bus.lifo_dout <= stk.pop_back();
    end
    stk_n <= stk.size();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int            idx;
    bit            op;
    logic [DW-1:0] data;
    bit            strobe;
    bit            err;
    logic [DW-1:0] rdata;
  } vec_t;

  function automatic vec_t mk(input int idx, input bit op, input logic [DW-1:0] data,
                              input bit strobe, input bit err, input logic [DW-1:0] rdata);
    vec_t v;
    v.idx = idx; v.op = op; v.data = data; v.strobe = strobe; v.err = err; v.rdata = rdata;
    return v;
  endfunction

  // One isolated transaction; entered and left just after a falling edge
  task automatic xact(input vec_t v);
    bus.req_valid = '0;
    bus.req_valid[v.idx] = 1'b1;
    bus.req_op[v.idx] = v.op;
    bus.req_data[v.idx*DW +: DW] = v.data;
    #1 chk("grant", int'(bus.req_ready), 1 << v.idx);
    @(posedge clk); @(negedge clk);
    bus.req_valid = '0;
    #1 chk("push_strobe", int'(bus.lifo_push), int'(v.strobe && !v.op));
    chk("pop_strobe", int'(bus.lifo_pop), int'(v.strobe && v.op));
    if (v.strobe && !v.op) chk("push_din", int'(bus.lifo_din), int'(v.data));
    @(posedge clk); @(negedge clk);
    #1 chk("rsp_early", int'(bus.rsp_valid), 0);
    @(posedge clk); @(negedge clk);
    #1 chk("rsp_valid", int'(bus.rsp_valid), 1 << v.idx);
    chk("rsp_err", int'(bus.rsp_err), int'(v.err));
    chk("rsp_data", int'(bus.rsp_data), int'(v.rdata));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    bus.lifo_error = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ready"}, int'(bus.req_ready), 0);
    chk({nm, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    chk({nm, "_push"}, int'(bus.lifo_push), 0);
    chk({nm, "_pop"}, int'(bus.lifo_pop), 0);
    chk({nm, "_din"}, int'(bus.lifo_din), 0);
    chk({nm, "_rsp_data"}, int'(bus.rsp_data), 0);
    chk({nm, "_rsp_err"}, int'(bus.rsp_err), 0);
  endtask

  // Random-phase model state
  int            free_at, strobe_cyc, rsp_cyc, ptr, win, r_idx;
  bit            s_op, s_ok, r_err;
  logic [DW-1:0] s_din, r_data;
  logic [DW-1:0] ref_stk[$];
  bit            pv[NREQ];
  bit            po[NREQ];
  logic [DW-1:0] pd[NREQ];

  initial begin
    vec_t tbl[$];
    tbl.push_back(mk(1, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00));
    tbl.push_back(mk(0, 1'b0, 8'h12, 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h12));
    tbl.push_back(mk(0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00));
    for (int i = 0; i < DEPTH; i++) tbl.push_back(mk(i % 2, 1'b0, DW'(100 + i), 1'b1, 1'b0, 8'h00));
    tbl.push_back(mk(0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h00));
    tbl.push_back(mk(0, 1'b1, 8'h00, 1'b1, 1'b0, 8'd115));
    tbl.push_back(mk(1, 1'b1, 8'h00, 1'b1, 1'b0, 8'd114));

    rst = 1'b0;
    bus.req_valid = '0; bus.req_op = '0; bus.req_data = '0; bus.lifo_error = 1'b0;
    repeat (3) @(negedge clk);
    bus.req_valid = 2'b11;
    #1 chk_all_zero("reset");
    bus.req_valid = '0;
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) xact(tbl[i]);

    // Contention: both push in the same cycle, then two pops by requester 0
    bus.req_valid = 2'b11; bus.req_op = 2'b00; bus.req_data = {8'hB2, 8'hA1};
    #1 chk("cont_first", int'(bus.req_ready), 1);
    @(posedge clk); @(negedge clk);
    bus.req_valid = 2'b10;
    #1 chk("cont_busy", int'(bus.req_ready), 0);
    chk("cont_din0", int'(bus.lifo_din), 8'hA1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1 chk("cont_rsp0", int'(bus.rsp_valid), 1);
    chk("cont_second", int'(bus.req_ready), 2);
    @(posedge clk); @(negedge clk);
    bus.req_valid = '0;
    #1 chk("cont_din1", int'(bus.lifo_din), 8'hB2);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1 chk("cont_rsp1", int'(bus.rsp_valid), 2);
    xact(mk(0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hB2));
    xact(mk(0, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA1));

    // Fairness with both requesters pushing continuously
    do_reset();
    bus.req_valid = 2'b11; bus.req_op = 2'b00; bus.req_data = {8'hB0, 8'hA0};
    for (int g = 0; g < 4; g++) begin
      int w;
`ifdef LIFO_ARB_PRIO_EN
      w = 0;
`else
      w = g % 2;
`endif
      #1 chk("fair_grant", int'(bus.req_ready), 1 << w);
      @(posedge clk); @(negedge clk);
      bus.req_data[w*DW +: DW] = DW'(8'hC0 + g);
      if (g == 3) bus.req_valid = '0;
      #1 chk("fair_busy", int'(bus.req_ready), 0);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      #1 chk("fair_rsp", int'(bus.rsp_valid), 1 << w);
    end

    // Reset during the ISSUE cycle of a push
    do_reset();
    xact(mk(0, 1'b0, 8'h34, 1'b1, 1'b0, 8'h00));
    xact(mk(0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h34));
    bus.req_valid = 2'b01; bus.req_op = 2'b00; bus.req_data = {8'h00, 8'h77};
    #1 chk("mid_grant", int'(bus.req_ready), 1);
    @(posedge clk); @(negedge clk);
    bus.req_valid = 2'b10;
    #1 chk("mid_push", int'(bus.lifo_push), 1);
    chk("mid_din", int'(bus.lifo_din), 8'h77);
    rst = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(posedge clk); @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("post_rst_rsp", int'(bus.rsp_valid), 0);
      @(posedge clk); @(negedge clk);
    end
    bus.req_valid = 2'b11;
    #1 chk("post_rst_grant", int'(bus.req_ready), 1);
    @(posedge clk); @(negedge clk);
    bus.req_valid = '0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1 chk("post_rst_rsp0", int'(bus.rsp_valid), 1);

    // Random traffic against the transaction-level model
    do_reset();
    free_at = 0; strobe_cyc = -1; rsp_cyc = -1; ptr = 0; r_idx = 0;
    s_op = 1'b0; s_ok = 1'b0; r_err = 1'b0; s_din = '0; r_data = '0;
    ref_stk.delete();
    for (int i = 0; i < NREQ; i++) begin pv[i] = 1'b0; po[i] = 1'b0; pd[i] = '0; end
    for (int cyc = 0; cyc < NRAND + 8; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (cyc >= NRAND) pv[i] = 1'b0;
        else if (!pv[i] && $urandom_range(0, 99) < 45) begin
          pv[i] = 1'b1;
          po[i] = ($urandom_range(0, 99) < ((cyc < NRAND / 2) ? 25 : 70));
          pd[i] = DW'($urandom);
        end else if (pv[i] && $urandom_range(0, 99) < 3) pv[i] = 1'b0;
        bus.req_valid[i] = pv[i];
        bus.req_op[i] = po[i];
        bus.req_data[i*DW +: DW] = pd[i];
      end
      bus.lifo_error = ($urandom_range(0, 3) == 0);
      if (cyc == rsp_cyc - 1) begin
        if (s_op && s_ok) bus.lifo_error = 1'b0;
        if (bus.lifo_error) r_err = 1'b1;
      end
      #1;
      win = -1;
      if (cyc >= free_at) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
`ifdef LIFO_ARB_PRIO_EN
          idx = k;
`else
          idx = (ptr + k) % NREQ;
`endif
          if (win < 0 && pv[idx]) win = idx;
        end
      end
      chk("rnd_ready", int'(bus.req_ready), (win >= 0) ? (1 << win) : 0);
      chk("rnd_push", int'(bus.lifo_push), int'(cyc == strobe_cyc && !s_op && s_ok));
      chk("rnd_pop", int'(bus.lifo_pop), int'(cyc == strobe_cyc && s_op && s_ok));
      if (cyc == strobe_cyc && !s_op && s_ok) chk("rnd_din", int'(bus.lifo_din), int'(s_din));
      chk("rnd_rsp_valid", int'(bus.rsp_valid), (cyc == rsp_cyc) ? (1 << r_idx) : 0);
      if (cyc == rsp_cyc) begin
        chk("rnd_rsp_err", int'(bus.rsp_err), int'(r_err));
        chk("rnd_rsp_data", int'(bus.rsp_data), int'(r_data));
      end
      if (win >= 0) begin
        s_op = po[win];
        s_din = pd[win];
        if (!s_op) begin
          s_ok = (ref_stk.size() < DEPTH);
          if (s_ok) ref_stk.push_back(s_din);
          r_data = '0;
        end else begin
          s_ok = (ref_stk.size() > 0);
          r_data = s_ok ? ref_stk.pop_back() : '0;
        end
        r_err = !s_ok;
        r_idx = win;
        strobe_cyc = cyc + 1;
        rsp_cyc = cyc + 3;
        free_at = cyc + 3;
        ptr = (win + 1) % NREQ;
        pv[win] = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    bus.lifo_error = 1'b0;
    bus.req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/lifo_arbiter.md
# lifo_arbiter

Arbitrates one shared 8-bit LIFO stack (depth 16) among NREQ requesters. Each requester issues push or pop transactions over a valid/ready handshake and gets a per-transaction response. The block serialises these requests onto the single push/pop port, gates illegal operations, and returns popped data. It sits between the requesting datapath blocks and the `lifo` instance.

## Interface
- `NREQ`, 2: number of requesters, 2..4.
- `DW`, 8: data width; must match the LIFO.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_op`  in  NREQ  operation per requester: 0 = push, 1 = pop.
- `req_data`  in  NREQ*DW  push data; requester i occupies bits [i*DW +: DW].
- `req_ready`  out  NREQ  one-hot grant; a transfer happens when `req_valid[i] && req_ready[i]`.
- `rsp_valid`  out  NREQ  one-cycle, one-hot response pulse to the granted requester.
- `rsp_data`  out  DW  popped data; 0 for push responses and for errors.
- `rsp_err`  out  1  operation rejected or LIFO reported an error; qualified by `rsp_valid`.
- `lifo_push`, `lifo_pop`  out  1 each  strobes to the LIFO.
- `lifo_din`  out  DW  LIFO write data.
- `lifo_dout`  in  DW  LIFO read data.
- `lifo_full`, `lifo_empty`, `lifo_error`  in  1 each  LIFO status flags.

## Operation
FSM states: IDLE, ISSUE, CAPT.

- **IDLE**
  - Arbitration is combinational over `req_valid`.
  - `req_ready` is asserted for the winner only, and only in IDLE.
  - On a transfer edge: latch winner index, op and data; go to ISSUE.
  - If no request is valid, stay in IDLE.
- **ISSUE**
  - Push with `lifo_full`=0: assert `lifo_push`; `lifo_din` = latched data.
  - Pop with `lifo_empty`=0: assert `lifo_pop`.
  - Otherwise: no strobe; set the internal reject flag.
  - Always go to CAPT.
- **CAPT**
  - On the edge leaving CAPT, register the response:
    - `rsp_valid[winner]` = 1.
    - `rsp_err` = reject | `lifo_error`.
    - `rsp_data` = `lifo_dout` for a successful pop, else 0.
  - Go to IDLE.
- **Arbitration**
  - Round-robin: the search starts at the pointer.
  - On each transfer, the pointer advances to (winner+1) mod NREQ.
- **Strobes**
  - `lifo_push` and `lifo_pop` are never asserted together.
  - They are never asserted outside ISSUE.
- **Simultaneous requests** are serialised, one transaction at a time, in arbitration order.
- **Request holding:** requesters hold `req_valid`, `req_op` and `req_data` stable until `req_ready`. A request withdrawn before grant is ignored.
- **Reset (`rst`=0)**, asynchronous:
  - State = IDLE; pointer = 0.
  - All outputs = 0; `req_ready` = 0.
  - An in-flight transaction is dropped with no response. The LIFO is reset by its own reset.

## Timing
- Transfer at edge E0. `lifo_push`/`lifo_pop` high during the cycle after E0. `rsp_valid` high for exactly one cycle, the cycle after E2.
- Throughput: one transaction per 3 cycles.
- A new transfer may occur in the same IDLE cycle in which `rsp_valid` is high.
- Full/empty decisions use the flags sampled during ISSUE. Earlier ops have completed by then, so the flags are current.
- `rsp_data` and `rsp_err` hold their values until the next response or reset; they are only meaningful while `rsp_valid` is high.

## Configuration
- `LIFO_ARB_PRIO_EN`
  - Defined: fixed priority, lowest index wins; the round-robin pointer is not implemented.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- **Reset:** drive `rst`=0 mid-ISSUE of a push.
  - Expect: all outputs 0 asynchronously.
  - Expect: no `rsp_valid` after release.
  - Expect: next grant goes to requester 0.
- **Single push:** req0 pushes 0x12.
  - Expect: `req_ready[0]` = 1 in the request cycle.
  - Expect: `lifo_push` = 1 with `lifo_din` = 0x12 in the next cycle.
  - Expect: `rsp_valid[0]` pulse 3 cycles after request, with `rsp_err` = 0 and `rsp_data` = 0x00.
- **Contention:** req0 pushes 0xA1 and req1 pushes 0xB2 in the same cycle, then req0 pops twice.
  - Expect: req0 is granted first, then req1.
  - Expect: the pops return 0xB2, then 0xA1.
- **Pop on empty:** after reset, req1 pops.
  - Expect: no `lifo_pop`.
  - Expect: `rsp_valid[1]` pulse with `rsp_err` = 1 and `rsp_data` = 0x00.
- **Full:** push values 100..115, then push 0xFF.
  - Expect: the 17th push produces no `lifo_push`, and its response has `rsp_err` = 1.
  - Expect: a following pop returns 115 (0x73).
- **Fairness:** req0 and req1 hold continuous pushes.
  - Without `LIFO_ARB_PRIO_EN`: grants alternate 0,1,0,1.
  - With `LIFO_ARB_PRIO_EN`: req0 wins every grant.
